battery_bar_ctrl: RTL

Parametrised battery-level indicator for the robot-vacuum front panel. It takes N_SENSE thermometer-coded charge sensors, synchronises and debounces them, and drives an N_LEDS bar graph. It flags invalid codes through a sticky error latch with an RGB status output, blinks the bar when charge is at the lowest level, and exports the debounced level count to the 7-segment display controller.

---
 rtl/battery_pkg.sv | 39 +++
 rtl/sense_debounce.sv | 56 +++++
 rtl/battery_bar_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/battery_pkg.sv
// Shared types and helpers for the battery bar-graph controller.
package battery_pkg;

  localparam int MAX_SENSE = 32;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    NORMAL = 2'd1,
    LOW    = 2'd2,
    ERROR  = 2'd3
  } bat_state_t;

  // Number of lit LEDs for level k; never fewer than one so LOW stays visible.
  function automatic int lit_count(input int k, input int n_sense, input int n_leds);
    int v;
    v = (k * n_leds) / n_sense;
    return (v < 1) ? 1 : v;
  endfunction

  // A good code has bit 0 set and no set bit above a clear one.
  function automatic logic thermo_valid(input logic [MAX_SENSE-1:0] code);
    logic ok;
    ok = code[0];
    for (int i = 1; i < MAX_SENSE; i++) begin
      if (code[i] && !code[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int count_ones(input logic [MAX_SENSE-1:0] code);
    int n;
    n = 0;
    for (int i = 0; i < MAX_SENSE; i++) begin
      n = n + int'(code[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sense_debounce.sv
// Two-flop synchroniser plus consecutive-sample filter for the charge sensors.
module sense_debounce #(
  parameter int WIDTH      = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_sense,
  output logic [WIDTH-1:0] o_deb,
  output logic             o_deb_valid
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_deb;
  logic             r_deb_valid;

  // r_sync1 is the sample about to enter r_sync2, so comparing the two counts
  // runs of equal synchronised samples without an extra pipeline stage.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_sync1 != r_sync2) begin
      w_cnt_next = CW'(1);
    end else if (r_cnt != CW'(DEB_CYCLES)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_cnt       <= '0;
      r_deb       <= '0;
      r_deb_valid <= 1'b0;
    end else begin
      r_sync1 <= i_sense;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;
      if (w_cnt_next == CW'(DEB_CYCLES)) begin
        r_deb       <= r_sync1;
        r_deb_valid <= 1'b1;
      end
    end
  end

  // o_deb is meaningful only while o_deb_valid=1; once set, valid stays set
  // until reset and o_deb changes only on an accepted debounce.
  assign o_deb       = r_deb;
  assign o_deb_valid = r_deb_valid;

endmodule

// File: rtl/battery_bar_ctrl.sv
// Battery level bar-graph controller with sticky code error and RGB status.
// Optional LOW-level blink is built when BATTERY_LOW_BLINK_EN is defined.
module battery_bar_ctrl
  import battery_pkg::*;
#(
  parameter int N_SENSE    = 3,
  parameter int N_LEDS     = 10,
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_HALF = 8,
  localparam int LW        = $clog2(N_SENSE + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SENSE-1:0] sense_in,
  input  logic               en,
  input  logic               err_clr,
  output logic [N_LEDS-1:0]  led_bar,
  output logic               err_out,
  output logic               rgb_green,
  output logic               rgb_red,
  output logic [LW-1:0]      level_out,
  output logic [1:0]         dbg_state
);

  logic [N_SENSE-1:0] w_deb;
  logic               w_deb_valid;
  logic               w_code_ok;
  int                 w_k;
  logic               r_err;
  logic               w_err_next;
  bat_state_t         r_state;
  bat_state_t         w_state_next;
  logic [LW-1:0]      r_level;
  logic [N_LEDS-1:0]  w_bar;
  logic               w_blink_on;

  sense_debounce #(
    .WIDTH      (N_SENSE),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sense     (sense_in),
    .o_deb       (w_deb),
    .o_deb_valid (w_deb_valid)
  );

  assign w_code_ok = thermo_valid(MAX_SENSE'(w_deb));
  assign w_k       = count_ones(MAX_SENSE'(w_deb));

  // Set dominates clear; clear is honoured only against a good code.
  always_comb begin
    w_err_next = r_err;
    if (w_deb_valid && !w_code_ok) begin
      w_err_next = 1'b1;
    end else if (err_clr && w_deb_valid && w_code_ok) begin
      w_err_next = 1'b0;
    end
  end

  // An invalid code enters ERROR on the same edge the latch sets; a clear
  // leaves ERROR one edge after the latch drops.
  always_comb begin
    w_state_next = NORMAL;
    if (!en || !w_deb_valid) begin
      w_state_next = OFF;
    end else if (r_err || !w_code_ok) begin
      w_state_next = ERROR;
    end else if (w_k == 1) begin
      w_state_next = LOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_err   <= 1'b0;
      r_level <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      r_level <= w_deb_valid ? LW'(w_k) : '0;
    end
  end

`ifdef BATTERY_LOW_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_state_next == LOW && r_state != LOW) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blink_on = r_phase;
`else
  assign w_blink_on = (BLINK_HALF > 0);
`endif

  // Bar mask follows the registered level so it moves with level_out.
  always_comb begin
    w_bar = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_bar[i] = (i < lit_count(int'(r_level), N_SENSE, N_LEDS));
    end
  end

  always_comb begin
    led_bar   = '0;
    err_out   = 1'b0;
    rgb_green = 1'b0;
    rgb_red   = 1'b0;
    case (r_state)
      NORMAL: begin
        led_bar   = w_bar;
        rgb_green = 1'b1;
      end
      LOW: begin
        led_bar   = w_blink_on ? w_bar : '0;
        rgb_green = 1'b1;
      end
      ERROR: begin
        err_out = r_err;
        rgb_red = r_err;
      end
      default: ;
    endcase
  end

  assign level_out = r_level;
  assign dbg_state = r_state;

endmodule
